// File: rtl/mastermind_scorer.sv
// mastermind_scorer
//   Mastermind game engine. Holds a secret code of PEGS colour pegs, accepts
//   guesses over a valid/ready handshake and scores each one sequentially:
//   one cycle for exact (red) matches, then one cycle per code peg for the
//   colour-only (white) search, then a one-cycle result pulse. Duplicate
//   colours are handled by used-flags on both code and guess pegs, so each
//   peg contributes to at most one match.
//
// Ports
//   clk           rising-edge clock
//   resetn        synchronous, active-low reset (returns to IDLE)
//   code_load     pulse: load code_in and start a new game (highest priority)
//   code_in       secret code, peg i at [i*COLOR_W +: COLOR_W]
//   guess_valid   guess_in is presented
//   guess_in      guess, same packing as code_in
//   guess_ready   engine accepts a guess this cycle
//   result_valid  one-cycle pulse when red/white/guesses_used update
//   red, white    scores of the last guess
//   guesses_used  guesses scored in the current game (saturating)
//   win, lose     sticky game status, cleared by code_load or reset
module mastermind_scorer #(
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8,
  localparam int CNT_W      = $clog2(PEGS + 1),
  localparam int GW         = $clog2(MAX_GUESSES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    code_load,
  input  logic [PEGS*COLOR_W-1:0] code_in,
  input  logic                    guess_valid,
  input  logic [PEGS*COLOR_W-1:0] guess_in,
  output logic                    guess_ready,
  output logic                    result_valid,
  output logic [CNT_W-1:0]        red,
  output logic [CNT_W-1:0]        white,
  output logic [GW-1:0]           guesses_used,
  output logic                    win,
  output logic                    lose
);

  localparam int IDX_W = (PEGS > 1) ? $clog2(PEGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PEGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_RED,
    S_WHITE,
    S_DONE,
    S_OVER
  } state_t;

  state_t                    state_reg;
  logic [PEGS*COLOR_W-1:0]   code_reg;
  logic [PEGS*COLOR_W-1:0]   guess_reg;
  logic [PEGS-1:0]           code_used_reg;
  logic [PEGS-1:0]           guess_used_reg;
  logic [CNT_W-1:0]          red_acc_reg;
  logic [CNT_W-1:0]          white_acc_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic                      ready_reg;
  logic                      result_valid_reg;
  logic [CNT_W-1:0]          red_reg;
  logic [CNT_W-1:0]          white_reg;
  logic [GW-1:0]             guesses_used_reg;
  logic                      win_reg;
  logic                      lose_reg;

  // Unpacked views of the stored code and guess.
  logic [COLOR_W-1:0] code_peg  [PEGS];
  logic [COLOR_W-1:0] guess_peg [PEGS];

  genvar gi;
  generate
    for (gi = 0; gi < PEGS; gi++) begin : g_unpack
      assign code_peg[gi]  = code_reg[gi*COLOR_W +: COLOR_W];
      assign guess_peg[gi] = guess_reg[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  // Exact matches, all pegs in parallel (used in the RED cycle).
  logic [PEGS-1:0]  exact_next;
  logic [CNT_W-1:0] red_next;

  always_comb begin
    exact_next = '0;
    red_next   = '0;
    for (int i = 0; i < PEGS; i++) begin
      if (code_peg[i] == guess_peg[i]) begin
        exact_next[i] = 1'b1;
        red_next      = red_next + CNT_W'(1);
      end
    end
  end

  // Colour-only search for code peg idx: lowest unused guess peg of the same
  // colour. Skipped entirely when the code peg was already an exact match.
  logic [COLOR_W-1:0] code_sel;
  logic               code_sel_used;
  logic               hit;
  logic [PEGS-1:0]    hit_mask;
  logic [CNT_W-1:0]   white_next;

  always_comb begin
    code_sel      = '0;
    code_sel_used = 1'b0;
    for (int i = 0; i < PEGS; i++) begin
      if (IDX_W'(i) == idx_reg) begin
        code_sel      = code_peg[i];
        code_sel_used = code_used_reg[i];
      end
    end
    hit      = 1'b0;
    hit_mask = '0;
    for (int j = 0; j < PEGS; j++) begin
      if (!code_sel_used && !hit && !guess_used_reg[j] && (guess_peg[j] == code_sel)) begin
        hit         = 1'b1;
        hit_mask[j] = 1'b1;
      end
    end
    white_next = white_acc_reg + (hit ? CNT_W'(1) : CNT_W'(0));
  end

  logic [GW-1:0] used_next;
  assign used_next = (guesses_used_reg == GW'(MAX_GUESSES)) ? guesses_used_reg
                                                           : guesses_used_reg + GW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg        <= S_IDLE;
      code_reg         <= '0;
      guess_reg        <= '0;
      code_used_reg    <= '0;
      guess_used_reg   <= '0;
      red_acc_reg      <= '0;
      white_acc_reg    <= '0;
      idx_reg          <= '0;
      ready_reg        <= 1'b0;
      result_valid_reg <= 1'b0;
      red_reg          <= '0;
      white_reg        <= '0;
      guesses_used_reg <= '0;
      win_reg          <= 1'b0;
      lose_reg         <= 1'b0;
    end else if (code_load) begin
      // New game: abort anything in flight and clear all visible status.
      state_reg        <= S_READY;
      code_reg         <= code_in;
      ready_reg        <= 1'b1;
      result_valid_reg <= 1'b0;
      red_reg          <= '0;
      white_reg        <= '0;
      guesses_used_reg <= '0;
      win_reg          <= 1'b0;
      lose_reg         <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: ;
        S_READY: begin
          if (guess_valid) begin
            guess_reg <= guess_in;
            ready_reg <= 1'b0;
            state_reg <= S_RED;
          end
        end
        S_RED: begin
          red_acc_reg    <= red_next;
          code_used_reg  <= exact_next;
          guess_used_reg <= exact_next;
          white_acc_reg  <= '0;
          idx_reg        <= '0;
          state_reg      <= S_WHITE;
        end
        S_WHITE: begin
          guess_used_reg <= guess_used_reg | hit_mask;
          white_acc_reg  <= white_next;
          idx_reg        <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            // Publish the result so it is visible during the DONE cycle.
            state_reg        <= S_DONE;
            result_valid_reg <= 1'b1;
            red_reg          <= red_acc_reg;
            white_reg        <= white_next;
            guesses_used_reg <= used_next;
            if (red_acc_reg == CNT_W'(PEGS)) begin
              win_reg <= 1'b1;
            end else if (used_next == GW'(MAX_GUESSES)) begin
              lose_reg <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (win_reg || lose_reg) begin
            state_reg <= S_OVER;
          end else begin
            state_reg <= S_READY;
            ready_reg <= 1'b1;
          end
        end
        S_OVER: ;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // A guess in the same cycle as code_load is never accepted.
  assign guess_ready  = ready_reg & ~code_load;
  assign result_valid = result_valid_reg;
  assign red          = red_reg;
  assign white        = white_reg;
  assign guesses_used = guesses_used_reg;
  assign win          = win_reg;
  assign lose         = lose_reg;

endmodule

// File: tb/tb_mastermind_scorer.sv
module tb_mastermind_scorer;

  localparam int PEGS        = 4;
  localparam int COLOR_W     = 3;
  localparam int MAX_GUESSES = 8;
  localparam int CNT_W       = $clog2(PEGS + 1);
  localparam int GW          = $clog2(MAX_GUESSES + 1);
  localparam int W           = PEGS * COLOR_W;
  localparam int NCOL        = 1 << COLOR_W;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             code_load = 1'b0;
  logic [W-1:0]     code_in = '0;
  logic             guess_valid = 1'b0;
  logic [W-1:0]     guess_in = '0;
  logic             guess_ready;
  logic             result_valid;
  logic [CNT_W-1:0] red;
  logic [CNT_W-1:0] white;
  logic [GW-1:0]    guesses_used;
  logic             win;
  logic             lose;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mastermind_scorer #(
    .PEGS(PEGS), .COLOR_W(COLOR_W), .MAX_GUESSES(MAX_GUESSES)
  ) dut (
    .clk(clk), .resetn(resetn), .code_load(code_load), .code_in(code_in),
    .guess_valid(guess_valid), .guess_in(guess_in), .guess_ready(guess_ready),
    .result_valid(result_valid), .red(red), .white(white),
    .guesses_used(guesses_used), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int red;
    int white;
    int used;
    bit win;
    bit lose;
    int cyc;
  } exp_t;

  exp_t sb[$];

  // Reference scoring: red by position, total colour overlap by histogram.
  function automatic void score(input logic [W-1:0] c, input logic [W-1:0] g,
                                output int r, output int w);
    int cc[NCOL];
    int gc[NCOL];
    int tot;
    int cv;
    int gv;
    r = 0;
    tot = 0;
    for (int k = 0; k < NCOL; k++) begin
      cc[k] = 0;
      gc[k] = 0;
    end
    for (int i = 0; i < PEGS; i++) begin
      cv = int'(c[i*COLOR_W +: COLOR_W]);
      gv = int'(g[i*COLOR_W +: COLOR_W]);
      if (cv == gv) r++;
      cc[cv]++;
      gc[gv]++;
    end
    for (int k = 0; k < NCOL; k++) tot += (cc[k] < gc[k]) ? cc[k] : gc[k];
    w = tot - r;
  endfunction

  function automatic logic [W-1:0] pack4(input int p0, input int p1, input int p2, input int p3);
    logic [W-1:0] v;
    v = '0;
    v[0*COLOR_W +: COLOR_W] = COLOR_W'(p0);
    v[1*COLOR_W +: COLOR_W] = COLOR_W'(p1);
    v[2*COLOR_W +: COLOR_W] = COLOR_W'(p2);
    v[3*COLOR_W +: COLOR_W] = COLOR_W'(p3);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_code(input int maxc);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < PEGS; i++) v[i*COLOR_W +: COLOR_W] = COLOR_W'($urandom_range(0, maxc));
    return v;
  endfunction

  // Game-level reference model: predicts guess_ready and queues expected results.
  logic [W-1:0] m_code = '0;
  bit m_ready = 0;
  bit m_wait = 0;
  bit m_over = 0;
  int m_used = 0;
  int m_rel_cyc = 0;

  always @(negedge clk) begin
    bit   exp_ready;
    int   r;
    int   w;
    exp_t e;
    if (!resetn) begin
      m_ready = 0;
      m_wait  = 0;
      m_over  = 0;
      m_used  = 0;
      sb.delete();
    end else begin
      if (m_wait && cyc == m_rel_cyc) begin
        m_wait  = 0;
        m_ready = !m_over;
      end
      exp_ready = m_ready && !code_load;
      checks++;
      if (guess_ready !== exp_ready) begin
        errors++;
        $display("FAIL guess_ready @cyc %0d: got %0b expected %0b", cyc, guess_ready, exp_ready);
      end
      if (code_load) begin
        m_code  = code_in;
        m_used  = 0;
        m_over  = 0;
        m_wait  = 0;
        m_ready = 1;
        sb.delete();
      end else if (exp_ready && guess_valid) begin
        score(m_code, guess_in, r, w);
        if (m_used < MAX_GUESSES) m_used++;
        e.red   = r;
        e.white = w;
        e.used  = m_used;
        e.win   = (r == PEGS);
        e.lose  = !e.win && (m_used == MAX_GUESSES);
        e.cyc   = cyc + PEGS + 2;
        sb.push_back(e);
        m_ready   = 0;
        m_wait    = 1;
        m_rel_cyc = cyc + PEGS + 3;
        m_over    = e.win || e.lose;
      end
    end
  end

  // Monitor: pops on result_valid, otherwise expects outputs to hold.
  int  h_red = 0, h_white = 0, h_used = 0;
  bit  h_win = 0, h_lose = 0, clr_pend = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      h_red = 0; h_white = 0; h_used = 0; h_win = 0; h_lose = 0; clr_pend = 0;
    end else begin
      if (clr_pend) begin
        h_red = 0; h_white = 0; h_used = 0; h_win = 0; h_lose = 0;
        clr_pend = 0;
      end
      if (result_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result @cyc %0d: got result_valid=1 expected 0", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc || red !== CNT_W'(e.red) || white !== CNT_W'(e.white) ||
              guesses_used !== GW'(e.used) || win !== e.win || lose !== e.lose) begin
            errors++;
            $display("FAIL result @cyc %0d: got cyc=%0d r=%0d w=%0d used=%0d win=%0b lose=%0b expected cyc=%0d r=%0d w=%0d used=%0d win=%0b lose=%0b",
                     cyc, cyc, red, white, guesses_used, win, lose,
                     e.cyc, e.red, e.white, e.used, e.win, e.lose);
          end else begin
            $display("result @cyc %0d: red=%0d white=%0d used=%0d win=%0b lose=%0b",
                     cyc, red, white, guesses_used, win, lose);
          end
          h_red = e.red; h_white = e.white; h_used = e.used; h_win = e.win; h_lose = e.lose;
        end
      end else begin
        checks++;
        if (red !== CNT_W'(h_red) || white !== CNT_W'(h_white) || guesses_used !== GW'(h_used) ||
            win !== h_win || lose !== h_lose) begin
          errors++;
          $display("FAIL hold @cyc %0d: got r=%0d w=%0d used=%0d win=%0b lose=%0b expected r=%0d w=%0d used=%0d win=%0b lose=%0b",
                   cyc, red, white, guesses_used, win, lose, h_red, h_white, h_used, h_win, h_lose);
        end
      end
      if (code_load) clr_pend = 1;
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] c);
    code_in   = c;
    code_load = 1'b1;
    @(posedge clk);
    #1;
    code_load = 1'b0;
  endtask

  // Presents a guess until accepted; returns 1ns after the acceptance edge.
  task automatic do_guess(input logic [W-1:0] g);
    bit ok;
    ok = 0;
    guess_in    = g;
    guess_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (guess_ready) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout @cyc %0d: got no guess_ready expected acceptance", cyc);
    end
    @(posedge clk);
    #1;
    guess_valid = 1'b0;
  endtask

  task automatic wait_result();
    bit seen;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL result_timeout @cyc %0d: got no result_valid expected a result", cyc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset state
    resetn = 1'b0;
    code_in = pack4(1, 2, 3, 4);
    code_load = 1'b1;
    guess_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (guess_ready !== 1'b0 || result_valid !== 1'b0 || red !== '0 || white !== '0 ||
        guesses_used !== '0 || win !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%0b rv=%0b r=%0d w=%0d used=%0d win=%0b lose=%0b expected all 0",
               guess_ready, result_valid, red, white, guesses_used, win, lose);
    end
    @(posedge clk);
    #1;
    code_load = 1'b0;
    guess_valid = 1'b0;
    resetn = 1'b1;
    idle(2);

    // Winning guess, then guess_valid in OVER is ignored
    do_load(pack4(1, 2, 3, 4));
    do_guess(pack4(1, 2, 3, 4));
    wait_result();
    guess_valid = 1'b1;
    idle(10);
    guess_valid = 1'b0;

    // Permutation: all white
    do_load(pack4(1, 2, 3, 4));
    do_guess(pack4(4, 3, 2, 1));
    wait_result();
    idle(2);

    // Duplicates
    do_load(pack4(1, 1, 2, 2));
    do_guess(pack4(1, 2, 1, 1));
    wait_result();
    do_guess(pack4(5, 5, 5, 5));
    wait_result();

    // Lose after MAX_GUESSES misses, then reload clears status
    do_load(pack4(1, 2, 3, 4));
    for (int k = 0; k < MAX_GUESSES; k++) begin
      do_guess(pack4(0, 0, 0, 0));
      wait_result();
    end
    guess_valid = 1'b1;
    idle(10);
    guess_valid = 1'b0;
    do_load(pack4(7, 6, 5, 4));
    idle(3);

    // Abort during WHITE, new code in force afterwards
    do_load(pack4(1, 2, 3, 4));
    do_guess(pack4(1, 2, 3, 4));
    idle(2);
    do_load(pack4(3, 3, 0, 6));
    do_guess(pack4(3, 3, 0, 6));
    wait_result();

    // Continuous guess_valid with the guess changing every cycle
    do_load(pack4(7, 7, 7, 7));
    guess_valid = 1'b1;
    guess_in = rand_code(6);
    n = 0;
    for (int k = 0; k < 200 && n < 6; k++) begin
      @(negedge clk);
      if (guess_ready) n++;
      @(posedge clk);
      #1;
      guess_in = rand_code(6);
    end
    guess_valid = 1'b0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL streaming: got %0d acceptances expected 6", n);
    end
    idle(PEGS + 4);

    // Random games with a small colour set to force duplicates
    for (int gidx = 0; gidx < 20; gidx++) begin
      do_load(rand_code(3));
      for (int k = 0; k < MAX_GUESSES + 1 && !m_over; k++) begin
        do_guess(rand_code(3));
        if ($urandom_range(0, 1) == 0) wait_result();
      end
      idle(PEGS + 4);
    end

    // Reset in the middle of scoring
    do_load(pack4(1, 2, 3, 4));
    do_guess(pack4(2, 2, 3, 3));
    idle(2);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
# mastermind_scorer

Parametrised Mastermind game engine: holds a secret code of PEGS colour pegs, accepts guesses over a valid/ready handshake, and scores each one sequentially into red (right colour, right position) and white (right colour, wrong position) counts. Duplicate colours are scored correctly: each code peg and each guess peg is counted at most once. It also tracks guesses used and win/lose status. It sits between the switch/key input control FSM and the hex display decoders, and replaces the fixed 4-peg, 3-bit compare path.

## Interface
- PEGS, 4, number of pegs per code/guess (2..8)
- COLOR_W, 3, bits per peg colour
- MAX_GUESSES, 8, guesses allowed before loss (1..15)
- CNT_W (localparam), $clog2(PEGS+1), width of red/white counts
- GW (localparam), $clog2(MAX_GUESSES+1), width of guess counter
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- code_load  in  1  single-cycle pulse: load code_in, start a new game
- code_in  in  PEGS*COLOR_W  secret code; peg i is bits [i*COLOR_W +: COLOR_W]
- guess_valid  in  1  guess_in is presented
- guess_in  in  PEGS*COLOR_W  guess, same packing as code_in
- guess_ready  out  1  engine can accept a guess this cycle
- result_valid  out  1  single-cycle pulse: red/white updated
- red  out  CNT_W  exact-position matches of the last scored guess
- white  out  CNT_W  colour-only matches of the last scored guess
- guesses_used  out  GW  guesses scored in the current game
- win  out  1  last guess had red == PEGS; sticky until code_load/reset
- lose  out  1  MAX_GUESSES scored without a win; sticky until code_load/reset

## Operation
- States: IDLE (no code), READY, RED, WHITE, DONE, OVER.
- Reset: state IDLE. All outputs are 0, including guess_ready.
- code_load has priority over everything, in any state. It registers code_in, clears guesses_used, red, white, win and lose, aborts any scoring in progress (no result_valid), and moves to READY.
- READY: guess_ready=1 unless code_load is high that cycle. Acceptance (guess_valid & guess_ready) registers guess_in and moves to RED.
- RED (1 cycle):
  - Compares all pegs in parallel; red = number of i with code[i]==guess[i].
  - Sets code_used[i] and guess_used[i] for each exact match.
  - Clears the white accumulator and sets idx=0. Moves to WHITE.
- WHITE (PEGS cycles, idx 0..PEGS-1):
  - If !code_used[idx], find the lowest j with !guess_used[j] and guess[j]==code[idx]. If found, set guess_used[j] and add 1 to white.
  - Move to DONE after idx==PEGS-1.
- DONE (1 cycle):
  - result_valid=1; red and white outputs hold the new values.
  - guesses_used increments, saturating at MAX_GUESSES.
  - If red==PEGS: win=1, go to OVER. Else if the new guesses_used==MAX_GUESSES: lose=1, go to OVER. Else go to READY.
- OVER: guess_ready=0. red, white and guesses_used hold. Only code_load or reset leaves this state.
- guess_valid outside READY is ignored; the guess is not queued.
- Invariant: red+white ≤ PEGS; white equals the sum over colours of min(code count, guess count), minus red.

## Timing
- Acceptance edge = cycle 0. RED occupies cycle 1, WHITE occupies cycles 2..PEGS+1, DONE (result_valid) is cycle PEGS+2. With PEGS=4, result_valid arrives 6 cycles after acceptance.
- guess_ready is low from cycle 1 through DONE. It returns high the cycle after DONE, when the next state is READY. Maximum throughput is one guess per PEGS+3 cycles.
- Timing of code_load:
  - Outputs clear on the edge where code_load is sampled.
  - guess_ready goes high the following cycle.
  - A guess presented in the same cycle as code_load is not accepted.
- resetn low overrides code_load and returns the block to IDLE.
- win and lose change only at DONE, never both 1; they clear only on code_load or reset.

## Test plan
- Reset, load code pegs (p0..p3)=1,2,3,4, then guess 1,2,3,4 -> result_valid exactly 6 cycles after acceptance with red=4, white=0, win=1, guesses_used=1; guess_ready stays 0 afterward.
- Code 1,2,3,4, guess 4,3,2,1 -> red=0, white=4, win=0, guess_ready=1 the next cycle.
- Duplicates: code 1,1,2,2, guess 1,2,1,1 -> red=1, white=2. Then guess 5,5,5,5 -> red=0, white=0.
- Eight guesses of 0,0,0,0 against code 1,2,3,4 -> the 8th result_valid sets lose=1 and guesses_used=8; a later guess_valid produces no result; code_load clears lose and guesses_used to 0.
- code_load pulsed during the WHITE state -> no result_valid for the aborted guess; the new code is in force; guesses_used=0; guess_ready=1 on the next cycle.
- Hold guess_valid high continuously -> exactly one acceptance per PEGS+3 cycles, with red/white stable between result_valid pulses.
